// File: rtl/crono_countdown_if.sv
// Chronometer countdown bus: control levels and BCD preset from the FSM,
// plus the BCD count, run status and completion event returned to it.
interface crono_countdown_if;
    logic       ProgramarCrono;
    logic       InicioCrono;
    logic       CronoActivo;
    logic [7:0] prog_hh;
    logic [7:0] prog_mm;
    logic [7:0] prog_ss;
    logic [7:0] crono_hh;
    logic [7:0] crono_mm;
    logic [7:0] crono_ss;
    logic       corriendo;
    logic       FinalizoCrono;

    modport master (
        output ProgramarCrono, InicioCrono, CronoActivo,
        output prog_hh, prog_mm, prog_ss,
        input  crono_hh, crono_mm, crono_ss, corriendo, FinalizoCrono
    );

    modport slave (
        input  ProgramarCrono, InicioCrono, CronoActivo,
        input  prog_hh, prog_mm, prog_ss,
        output crono_hh, crono_mm, crono_ss, corriendo, FinalizoCrono
    );
endinterface

// File: rtl/crono_countdown.sv
// Countdown-timer datapath: loads a BCD HH:MM:SS preset, decrements it once
// per TICKS_PER_SEC counted cycles and pulses FinalizoCrono on reaching zero.
module crono_countdown #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter logic [7:0]  MAX_HH        = 8'h23
) (
    input  logic               clk,
    input  logic               reset,
    crono_countdown_if.slave   bus
);
    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state;
    logic [PRESC_W-1:0]   prescaler;
    logic [7:0]           hh, mm, ss;
    logic                 corriendo;
    logic                 finalizo;

    // Out-of-range fields clamp to their maximum; an in-range field holding
    // a non-decimal digit loads as 00.
    function automatic logic [7:0] loadField(input logic [7:0] v, input logic [7:0] maxV);
        if (v > maxV) return maxV;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9)) return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] wrapV);
        if (v == 8'h00) return wrapV;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic       ssBorrow, mmBorrow;
    logic [7:0] ssDec, mmDec, hhDec;
    logic       countEn, tick, decZero, valueZero, startOk;

    assign ssBorrow  = (ss == 8'h00);
    assign mmBorrow  = ssBorrow && (mm == 8'h00);
    assign ssDec     = bcdDec(ss, 8'h59);
    assign mmDec     = ssBorrow ? bcdDec(mm, 8'h59) : mm;
    assign hhDec     = mmBorrow ? bcdDec(hh, 8'h00) : hh;
    assign decZero   = ({hhDec, mmDec, ssDec} == 24'h000000);
    assign valueZero = ({hh, mm, ss} == 24'h000000);
    assign countEn   = (state == RUN) && bus.CronoActivo && bus.InicioCrono;
    assign tick      = countEn && (prescaler == PRESC_LAST);
    assign startOk   = !bus.ProgramarCrono && bus.InicioCrono && bus.CronoActivo;

    // Control FSM and datapath; a load always wins over a pending tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prescaler <= '0;
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            corriendo <= 1'b0;
            finalizo  <= 1'b0;
        end else begin
            finalizo <= 1'b0;
            if (bus.ProgramarCrono) begin
                hh        <= loadField(bus.prog_hh, MAX_HH);
                mm        <= loadField(bus.prog_mm, 8'h59);
                ss        <= loadField(bus.prog_ss, 8'h59);
                prescaler <= '0;
                state     <= LOAD;
                corriendo <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (startOk) begin
                            if (valueZero) begin
                                state    <= DONE;
                                finalizo <= 1'b1;
                            end else begin
                                state     <= RUN;
                                corriendo <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            prescaler <= '0;
                            hh        <= hhDec;
                            mm        <= mmDec;
                            ss        <= ssDec;
                            if (decZero) begin
                                state     <= DONE;
                                corriendo <= 1'b0;
                                finalizo  <= 1'b1;
                            end
                        end else if (countEn) begin
                            prescaler <= prescaler + PRESC_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.crono_hh      = hh;
    assign bus.crono_mm      = mm;
    assign bus.crono_ss      = ss;
    assign bus.corriendo     = corriendo;
    assign bus.FinalizoCrono = finalizo;
endmodule

// File: tb/tb_crono_countdown.sv
// Scoreboard bench for crono_countdown: a seconds-based reference model queues
// every expected output change and a negedge monitor pops and compares them.
module tb_crono_countdown;
    localparam int unsigned TPS  = 4;
    localparam int          HALF = 5;

    logic clk = 1'b0;
    logic reset;
    always #HALF clk = ~clk;

    crono_countdown_if bus();

    crono_countdown #(.TICKS_PER_SEC(TPS), .MAX_HH(8'h23)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        time        stamp;
        logic [25:0] obs;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   finSeen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the count is an integer number of seconds.
    function automatic int fieldDec(input logic [7:0] v, input logic [7:0] maxV);
        logic [7:0] x;
        int tens, ones;
        x = (v > maxV) ? maxV : v;
        tens = int'(x[7:4]);
        ones = int'(x[3:0]);
        if (tens > 9 || ones > 9) return 0;
        return tens * 10 + ones;
    endfunction

    function automatic logic [7:0] toBcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    int          mMode = 0;   // 0 idle, 1 loaded, 2 running, 3 done
    int          mSecs = 0;
    int          mPhase = 0;
    logic        mFin = 1'b0;
    logic [25:0] prevExp = '0;

    task automatic pushIfChanged();
        logic [25:0] e;
        exp_t rec;
        e = {toBcd(mSecs / 3600), toBcd((mSecs / 60) % 60), toBcd(mSecs % 60),
             (mMode == 2), mFin};
        if (e != prevExp || mFin) begin
            rec.stamp = $time;
            rec.obs   = e;
            expQ.push_back(rec);
        end
        prevExp = e;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mMode = 0; mSecs = 0; mPhase = 0; mFin = 1'b0;
            end else begin
                mFin = 1'b0;
                if (bus.ProgramarCrono) begin
                    mSecs = fieldDec(bus.prog_hh, 8'h23) * 3600 +
                            fieldDec(bus.prog_mm, 8'h59) * 60 +
                            fieldDec(bus.prog_ss, 8'h59);
                    mMode = 1; mPhase = 0;
                end else if (mMode == 1 && bus.InicioCrono && bus.CronoActivo) begin
                    if (mSecs == 0) begin mMode = 3; mFin = 1'b1; end
                    else mMode = 2;
                end else if (mMode == 2 && bus.InicioCrono && bus.CronoActivo) begin
                    mPhase++;
                    if (mPhase == int'(TPS)) begin
                        mPhase = 0;
                        mSecs--;
                        if (mSecs == 0) begin mMode = 3; mFin = 1'b1; end
                    end
                end
            end
            pushIfChanged();
        end
    end

    // Monitor: every change on the outputs (or a completion pulse) is an event.
    initial begin
        logic [25:0] obs, prevObs;
        exp_t e;
        int dt;
        prevObs = '0;
        forever begin
            @(negedge clk);
            obs = {bus.crono_hh, bus.crono_mm, bus.crono_ss, bus.corriendo, bus.FinalizoCrono};
            if (obs != prevObs || bus.FinalizoCrono) begin
                if (bus.FinalizoCrono) finSeen++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %h expected no change at %0t", obs, $time);
                end else begin
                    e = expQ.pop_front();
                    check("outputs", 32'(obs), 32'(e.obs));
                    dt = int'($time - e.stamp);
                    check("event_cycle", 32'(dt > 0 && dt <= HALF), 32'd1);
                end
            end
            prevObs = obs;
        end
    end

    task automatic drive(input logic p, input logic i, input logic a,
                         input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input int cycles);
        bus.ProgramarCrono = p;
        bus.InicioCrono    = i;
        bus.CronoActivo    = a;
        bus.prog_hh = h;
        bus.prog_mm = m;
        bus.prog_ss = s;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] dutVal();
        return {8'h00, bus.crono_hh, bus.crono_mm, bus.crono_ss};
    endfunction

    initial begin
        int f0;
        logic [7:0] h, m, s;
        reset = 1'b1;
        bus.ProgramarCrono = 1'b0; bus.InicioCrono = 1'b0; bus.CronoActivo = 1'b0;
        bus.prog_hh = 8'h00; bus.prog_mm = 8'h00; bus.prog_ss = 8'h00;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("reset_state",
              32'({bus.crono_hh, bus.crono_mm, bus.crono_ss, bus.corriendo, bus.FinalizoCrono}), 32'd0);
        reset = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 2);

        // 00:00:03 counts down to a single completion
        f0 = finSeen;
        drive(1, 0, 0, 8'h00, 8'h00, 8'h03, 1);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 16);
        check("t1_fin_count", 32'(finSeen - f0), 32'd1);
        check("t1_value", dutVal(), 32'h000000);
        check("t1_corriendo", 32'(bus.corriendo), 32'd0);

        // 01:00:00 double borrow
        drive(1, 0, 0, 8'h01, 8'h00, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 5);
        check("t2_borrow", dutVal(), 32'h005959);

        // pause holds value and prescaler phase
        drive(1, 0, 0, 8'h00, 8'h00, 8'h05, 1);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 5);
        check("t3_first_tick", dutVal(), 32'h000004);
        drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 20);
        check("t3_paused", dutVal(), 32'h000004);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 4);
        check("t3_resumed", dutVal(), 32'h000003);

        // zero preset completes at once
        f0 = finSeen;
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 1);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 8);
        check("t4_fin_count", 32'(finSeen - f0), 32'd1);
        check("t4_value", dutVal(), 32'h000000);

        // sanitise and clamp
        drive(1, 0, 0, 8'h3A, 8'h75, 8'h1F, 1);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 2);
        check("t5_clamp", dutVal(), 32'h235900);

        // reload mid-run, then reset mid-run
        f0 = finSeen;
        drive(1, 0, 0, 8'h00, 8'h00, 8'h02, 1);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 3);
        drive(1, 1, 1, 8'h00, 8'h00, 8'h02, 1);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 3);
        check("t6_reloaded", dutVal(), 32'h000002);
        pulseReset(2);
        drive(0, 1, 1, 8'h00, 8'h00, 8'h00, 10);
        check("t6_reset_value", dutVal(), 32'h000000);
        check("t6_no_fin", 32'(finSeen - f0), 32'd0);

        // randomized operation sequences
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                h = 8'h00; m = 8'h00; s = 8'($urandom_range(0, 9));
            end else begin
                h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
            end
            if ($urandom_range(0, 49) == 0) pulseReset($urandom_range(1, 2));
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), h, m, s, $urandom_range(1, 10));
        end

        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 10);
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
